dataload_seq_ctrl: RTL and testbench
====================================

// Module: dataload_seq_ctrl
// PURPOSE
//  Sequencer for the dataload block: pulls a 32-bit word stream from an upstream source and drives
//  data/load_en/load_type so each tile is loaded as W_WORDS weight words, then IN_WORDS input words.
//  Once both dataload valid flags are high, issues a one-cycle compute start and waits for compute done.
//  Repeats for the programmed tile count, then reports done. Sits between the source FIFO and dataload.
// PARAMETERS
//  DATA_W    32  word width of source and dataload data
//  W_WORDS   1   weight words per tile (the weight buffer depth)
//  IN_WORDS  8   input words per tile (256-bit input buffer / DATA_W)
//  TILE_W    8   width of the tile count and tile index
// PORTS
//  clk              in   1        clock, all state on rising edge
//  rst_n            in   1        asynchronous active-low reset
//  start_i          in   1        start a job; sampled only in IDLE
//  num_tiles_i      in   TILE_W   tiles in the job; captured at start
//  abort_i          in   1        synchronous abort; returns to IDLE next cycle
//  src_valid_i      in   1        source word valid
//  src_data_i       in   DATA_W   source word
//  src_ready_o      out  1        controller accepts a source word
//  load_data_o      out  DATA_W   to dataload data_i
//  load_en_o        out  1        to dataload load_en_i
//  load_type_o      out  1        to dataload load_type (0 = weight, 1 = input)
//  weight_valid_i   in   1        from dataload weight_valid
//  input_valid_i    in   1        from dataload input_valid
//  compute_start_o  out  1        one-cycle pulse: tile ready for compute
//  compute_done_i   in   1        compute finished for the current tile
//  tile_idx_o       out  TILE_W   index of the tile being processed
//  busy_o           out  1        high in every state except IDLE
//  done_o           out  1        one-cycle pulse at job end
// BEHAVIOUR
//  Reset: state=IDLE; word_cnt, tile_idx_o, stored tile count = 0; every output 0.
//  Transfer: a word moves when src_valid_i && src_ready_o. Datapath is combinational, zero latency:
//   load_data_o=src_data_i, load_en_o=src_valid_i&&src_ready_o, load_type_o=(state==LOAD_I).
//   src_ready_o=1 only in LOAD_W and LOAD_I.
//  FSM:
//   IDLE   : on start_i: if num_tiles_i==0, pulse done_o and stay in IDLE. Otherwise latch the count,
//            clear tile_idx and word_cnt, go to LOAD_W.
//   LOAD_W : count transfers; on transfer with word_cnt==W_WORDS-1, clear word_cnt and go to LOAD_I.
//   LOAD_I : same rule with IN_WORDS-1, then go to WAIT_V.
//   WAIT_V : when weight_valid_i && input_valid_i, go to FIRE. Waits indefinitely.
//   FIRE   : compute_start_o=1 for exactly this cycle, then go to WAIT_D.
//   WAIT_D : on compute_done_i: if tile_idx==count-1, pulse done_o next cycle (go to FIN).
//            Otherwise increment tile_idx and go to LOAD_W.
//   FIN    : done_o=1 for one cycle, then go to IDLE. tile_idx_o holds its last value until the next start.
//  No transfers occur outside LOAD_W and LOAD_I; upstream stalls (src_valid_i=0) are held without limit.
//  compute_done_i outside WAIT_D is ignored. start_i outside IDLE is ignored.
//  abort_i has priority over every transition. The next state is IDLE with counters cleared,
//   and no done_o or compute_start_o pulse. A transfer accepted in the abort cycle still reaches dataload.
//  Counters: word_cnt is $clog2(max(W_WORDS,IN_WORDS))+1 bits. tile_idx is TILE_W bits;
//   num_tiles=2^TILE_W-1 completes without wrap.
//  Reset asserted mid-job: outputs clear immediately (asynchronously); there is no resume.
// STRUCTURE
//  dataload_pkg holds: state enum (IDLE, LOAD_W, LOAD_I, WAIT_V, FIRE, WAIT_D, FIN) and the
//   LOAD_TYPE_WEIGHT=1'b0 / LOAD_TYPE_INPUT=1'b1 constants, shared with dataload.
//  Single module with one FSM and two counters; no sub-module. Top-level wrapper instantiates it with dataload.
// TESTING
//  1 start, num_tiles=1, src always valid, words 0..8 -> word 0 load_type=0, words 1..8 load_type=1,
//    compute_start one cycle after both valids; done_o one cycle after compute_done.
//  2 num_tiles=3, random src_valid gaps -> exactly 27 load_en pulses, 3 compute_start pulses,
//    tile_idx_o 0,1,2; one done_o.
//  3 num_tiles=0 -> done_o pulse the cycle after start, no load_en, busy_o stays 0.
//  4 abort_i during LOAD_I word 4 -> IDLE next cycle, src_ready_o=0, no done_o;
//    a new start with num_tiles=1 then completes normally.
//  5 input_valid_i held low 20 cycles in WAIT_V; compute_done_i pulsed during LOAD_W and start_i pulsed
//    mid-job -> no compute_start until valid rises, spurious done and start ignored.
//  6 rst_n asserted in WAIT_D -> all outputs 0 asynchronously; after release the state is IDLE.

Source files
------------

// File: rtl/dataload_seq_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dataload_seq_ctrl_pkg                                   |
// | Shared state encoding and load-type constants for the sequencer.  |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package dataload_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_I = 3'd2,
        WAIT_V = 3'd3,
        FIRE   = 3'd4,
        WAIT_D = 3'd5,
        FIN    = 3'd6
    } state_t;

    localparam logic LOAD_TYPE_WEIGHT = 1'b0;
    localparam logic LOAD_TYPE_INPUT  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dataload_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dataload_seq_ctrl_if                                    |
// | Job control, source stream and dataload/compute handshake bundle. |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
interface dataload_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int TILE_W = 8
);
    logic              start_i;
    logic [TILE_W-1:0] num_tiles_i;
    logic              abort_i;
    logic              src_valid_i;
    logic [DATA_W-1:0] src_data_i;
    logic              src_ready_o;
    logic [DATA_W-1:0] load_data_o;
    logic              load_en_o;
    logic              load_type_o;
    logic              weight_valid_i;
    logic              input_valid_i;
    logic              compute_start_o;
    logic              compute_done_i;
    logic [TILE_W-1:0] tile_idx_o;
    logic              busy_o;
    logic              done_o;

    // Controller side
    modport slave (
        input  start_i, num_tiles_i, abort_i, src_valid_i, src_data_i,
               weight_valid_i, input_valid_i, compute_done_i,
        output src_ready_o, load_data_o, load_en_o, load_type_o,
               compute_start_o, tile_idx_o, busy_o, done_o
    );

    // Environment side: job owner, source FIFO, dataload and compute
    modport master (
        output start_i, num_tiles_i, abort_i, src_valid_i, src_data_i,
               weight_valid_i, input_valid_i, compute_done_i,
        input  src_ready_o, load_data_o, load_en_o, load_type_o,
               compute_start_o, tile_idx_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/dataload_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : dataload_seq_ctrl                                       |
// | Streams weight then input words per tile into dataload, fires     |
// | compute, and repeats for the programmed tile count.               |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module dataload_seq_ctrl
    import dataload_seq_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int W_WORDS  = 1,
    parameter int IN_WORDS = 8,
    parameter int TILE_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dataload_seq_ctrl_if.slave   bus
);

    localparam int c_CNT_W = $clog2(max_int(W_WORDS, IN_WORDS)) + 1;
    localparam logic [c_CNT_W-1:0] c_W_LAST  = c_CNT_W'(W_WORDS - 1);
    localparam logic [c_CNT_W-1:0] c_IN_LAST = c_CNT_W'(IN_WORDS - 1);
    localparam logic [TILE_W-1:0]  c_TILE_ONE = TILE_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_word_cnt;
    logic [c_CNT_W-1:0]  w_word_cnt_nxt;
    logic [TILE_W-1:0]   r_tile_idx;
    logic [TILE_W-1:0]   w_tile_idx_nxt;
    logic [TILE_W-1:0]   r_num_tiles;
    logic [TILE_W-1:0]   w_num_tiles_nxt;
    logic                r_done_zero;
    logic                w_done_zero_nxt;
    logic                w_ready;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_load_data;

    assign w_ready     = (r_state == LOAD_W) || (r_state == LOAD_I);
    assign w_xfer      = bus.src_valid_i && w_ready;
    assign w_load_data = bus.src_data_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_word_cnt  <= '0;
            r_tile_idx  <= '0;
            r_num_tiles <= '0;
            r_done_zero <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_tile_idx  <= w_tile_idx_nxt;
            r_num_tiles <= w_num_tiles_nxt;
            r_done_zero <= w_done_zero_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_tile_idx_nxt  = r_tile_idx;
        w_num_tiles_nxt = r_num_tiles;
        w_done_zero_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start_i) begin
                    // An empty job still owes its requester a done pulse
                    if (bus.num_tiles_i == '0) begin
                        w_done_zero_nxt = 1'b1;
                    end else begin
                        w_num_tiles_nxt = bus.num_tiles_i;
                        w_tile_idx_nxt  = '0;
                        w_word_cnt_nxt  = '0;
                        w_state_nxt     = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (w_xfer) begin
                    if (r_word_cnt == c_W_LAST) begin
                        w_word_cnt_nxt = '0;
                        w_state_nxt    = LOAD_I;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            LOAD_I: begin
                if (w_xfer) begin
                    if (r_word_cnt == c_IN_LAST) begin
                        w_word_cnt_nxt = '0;
                        w_state_nxt    = WAIT_V;
                    end else begin
                        w_word_cnt_nxt = r_word_cnt + 1'b1;
                    end
                end
            end
            WAIT_V: begin
                if (bus.weight_valid_i && bus.input_valid_i) begin
                    w_state_nxt = FIRE;
                end
            end
            FIRE: begin
                w_state_nxt = WAIT_D;
            end
            WAIT_D: begin
                if (bus.compute_done_i) begin
                    if (r_tile_idx == (r_num_tiles - c_TILE_ONE)) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_tile_idx_nxt = r_tile_idx + c_TILE_ONE;
                        w_state_nxt    = LOAD_W;
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides every transition, including the zero-tile done
        if (bus.abort_i) begin
            w_state_nxt     = IDLE;
            w_word_cnt_nxt  = '0;
            w_tile_idx_nxt  = '0;
            w_num_tiles_nxt = '0;
            w_done_zero_nxt = 1'b0;
        end
    end

    assign bus.src_ready_o     = w_ready;
    assign bus.load_data_o     = w_load_data;
    assign bus.load_en_o       = w_xfer;
    assign bus.load_type_o     = (r_state == LOAD_I) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
    assign bus.compute_start_o = (r_state == FIRE);
    assign bus.tile_idx_o      = r_tile_idx;
    assign bus.busy_o          = (r_state != IDLE);
    assign bus.done_o          = (r_state == FIN) || r_done_zero;

endmodule
`default_nettype wire

// File: tb/tb_dataload_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_dataload_seq_ctrl                                    |
// | Directed vector table plus multi-cycle sequences for the sequencer|
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dataload_seq_ctrl;

    localparam int DATA_W     = 32;
    localparam int W_WORDS    = 1;
    localparam int IN_WORDS   = 8;
    localparam int TILE_W     = 8;
    localparam int TILE_WORDS = W_WORDS + IN_WORDS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dataload_seq_ctrl_if #(.DATA_W(DATA_W), .TILE_W(TILE_W)) bus();

    dataload_seq_ctrl #(
        .DATA_W  (DATA_W),
        .W_WORDS (W_WORDS),
        .IN_WORDS(IN_WORDS),
        .TILE_W  (TILE_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        start;
        logic [7:0]  num;
        logic        abort;
        logic        sv;
        logic [31:0] sd;
        logic        wv;
        logic        iv;
        logic        cd;
        logic        rdy;
        logic        en;
        logic        typ;
        logic        cs;
        logic        busy;
        logic        done;
        logic [7:0]  tile;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic st, input logic [7:0] n, input logic ab,
                                input logic sv, input logic [31:0] sd,
                                input logic wv, input logic iv, input logic cd,
                                input logic rdy, input logic en, input logic typ,
                                input logic cs, input logic bsy, input logic dn,
                                input logic [7:0] tl);
        vec_t v;
        v.start = st;  v.num = n;   v.abort = ab; v.sv = sv;   v.sd = sd;
        v.wv = wv;     v.iv = iv;   v.cd = cd;
        v.rdy = rdy;   v.en = en;   v.typ = typ;  v.cs = cs;
        v.busy = bsy;  v.done = dn; v.tile = tl;
        vq.push_back(v);
    endfunction

    // One-tile job: W word, 8 I words with a stall, valids, fire, done
    function automatic void add_job1();
        add(1, 8'd1, 0, 0, 32'h0,   0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h100, 0, 0, 0,  1, 1, 0, 0, 1, 0, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            add(0, 8'd0, 0, 1, 32'h100 + k, 0, 0, 0,  1, 1, 1, 0, 1, 0, 8'd0);
            if (k == 3)
                add(0, 8'd0, 0, 0, 32'hdead, 0, 0, 0,  1, 0, 1, 0, 1, 0, 8'd0);
        end
        add(0, 8'd0, 0, 1, 32'h109, 1, 0, 0,  0, 0, 0, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h10a, 1, 1, 0,  0, 0, 0, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 0, 32'h0,   1, 1, 0,  0, 0, 0, 1, 1, 0, 8'd0);
        add(0, 8'd0, 0, 0, 32'h0,   0, 0, 1,  0, 0, 0, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 0, 32'h0,   0, 0, 0,  0, 0, 0, 0, 1, 1, 8'd0);
        add(0, 8'd0, 0, 0, 32'h0,   0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] n, input logic ab,
                         input logic sv, input logic [31:0] sd,
                         input logic wv, input logic iv, input logic cd);
        bus.start_i        = st;
        bus.num_tiles_i    = n;
        bus.abort_i        = ab;
        bus.src_valid_i    = sv;
        bus.src_data_i     = sd;
        bus.weight_valid_i = wv;
        bus.input_valid_i  = iv;
        bus.compute_done_i = cd;
    endtask

    function automatic logic [45:0] outs();
        return {bus.src_ready_o, bus.load_en_o, bus.load_type_o, bus.compute_start_o,
                bus.busy_o, bus.done_o, bus.tile_idx_o, bus.load_data_o};
    endfunction

    task automatic step(input logic st, input logic [7:0] n, input logic ab,
                        input logic sv, input logic [31:0] sd,
                        input logic wv, input logic iv, input logic cd);
        @(posedge clk); #1;
        drive(st, n, ab, sv, sd, wv, iv, cd);
        @(negedge clk);
    endtask

    // Runs a complete job with always-ready valids and delayed compute_done
    task automatic run_job(input logic [7:0] n, input bit gaps, input int bound);
        int          n_en = 0, n_cs = 0, n_done = 0, wit = 0, cd_wait = 0;
        logic [31:0] d = 32'h0;
        logic        cdn;
        bit          fin = 0;
        step(1, n, 0, 0, 32'h0, 0, 0, 0);
        for (int c = 0; c < bound && !fin; c++) begin
            cdn = 1'b0;
            if (cd_wait > 0) begin
                cd_wait--;
                cdn = (cd_wait == 0);
            end
            step(0, 8'd0, 0, gaps ? ($urandom_range(0, 3) != 0) : 1'b1, d, 1, 1, cdn);
            if (bus.load_en_o) begin
                check("job_load_type", bus.load_type_o, (wit >= W_WORDS));
                wit = (wit + 1) % TILE_WORDS;
                n_en++;
                d++;
            end
            if (bus.compute_start_o) begin
                check("job_cs_tile", bus.tile_idx_o, n_cs);
                n_cs++;
                cd_wait = 2;
            end
            if (bus.done_o) begin
                n_done++;
                fin = 1;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: got no done after %0d cycles expected done", bound);
        end
        repeat (3) begin
            step(0, 8'd0, 0, 1, 32'h0, 1, 1, 1);
            if (bus.load_en_o)       n_en++;
            if (bus.compute_start_o) n_cs++;
            if (bus.done_o)          n_done++;
        end
        check("job_load_en_count", n_en, n * TILE_WORDS);
        check("job_cs_count", n_cs, n);
        check("job_done_count", n_done, 1);
        check("job_tile_hold", bus.tile_idx_o, n - 8'd1);
        check("job_busy_after", bus.busy_o, 0);
    endtask

    initial begin
        int   n_cs;
        logic pend;

        drive(0, 8'd0, 0, 0, 32'h0, 0, 0, 0);
        #12;
        check("reset_outputs", outs(), 46'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle cycle, then job 1
        add(0, 8'd0, 0, 0, 32'h0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        add_job1();
        // Zero-tile job: done next cycle, nothing loaded, never busy
        add(1, 8'd0, 0, 1, 32'h5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h6, 0, 0, 0,  0, 0, 0, 0, 0, 1, 8'd0);
        add(0, 8'd0, 0, 1, 32'h7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        // Abort on the fourth input word, then a clean job
        add(1, 8'd1, 0, 0, 32'h0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h10, 0, 0, 0,  1, 1, 0, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h1,  0, 0, 0,  1, 1, 1, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h2,  0, 0, 0,  1, 1, 1, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h3,  0, 0, 0,  1, 1, 1, 0, 1, 0, 8'd0);
        add(0, 8'd0, 1, 1, 32'h4,  0, 0, 0,  1, 1, 1, 0, 1, 0, 8'd0);
        add(0, 8'd0, 0, 1, 32'h5,  1, 1, 1,  0, 0, 0, 0, 0, 0, 8'd0);
        add(0, 8'd0, 0, 0, 32'h0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 8'd0);
        add_job1();

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].start, vq[i].num, vq[i].abort, vq[i].sv, vq[i].sd,
                 vq[i].wv, vq[i].iv, vq[i].cd);
            check($sformatf("vec%0d", i), outs(),
                  {vq[i].rdy, vq[i].en, vq[i].typ, vq[i].cs, vq[i].busy, vq[i].done,
                   vq[i].tile, vq[i].sd});
        end

        // Three tiles with random source gaps
        run_job(8'd3, 1'b1, 500);

        // Spurious compute_done in LOAD_W, spurious start in LOAD_I, long WAIT_V
        step(1, 8'd1, 0, 0, 32'h0, 0, 0, 0);
        step(0, 8'd0, 0, 0, 32'h0, 0, 0, 1);
        check("t5_cd_in_loadw_ready", bus.src_ready_o, 1);
        check("t5_tile_restart", bus.tile_idx_o, 0);
        step(0, 8'd0, 0, 0, 32'h0, 0, 0, 0);
        check("t5_still_loadw", {bus.src_ready_o, bus.load_type_o}, 2'b10);
        step(0, 8'd0, 0, 1, 32'h20, 0, 0, 0);
        check("t5_w_word", {bus.load_en_o, bus.load_type_o}, 2'b10);
        for (int k = 1; k <= 8; k++) begin
            step(k == 3, 8'd5, 0, 1, 32'h20 + k, 0, 0, 0);
            check($sformatf("t5_i_word%0d", k), {bus.load_en_o, bus.load_type_o, bus.tile_idx_o},
                  {2'b11, 8'd0});
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 8'd0, 0, 1, 32'h0, 1, 0, 0);
            check($sformatf("t5_waitv%0d", k),
                  {bus.compute_start_o, bus.src_ready_o, bus.load_en_o, bus.busy_o}, 4'b0001);
        end
        step(0, 8'd0, 0, 0, 32'h0, 1, 1, 0);
        check("t5_valid_rise_no_cs", bus.compute_start_o, 0);
        step(0, 8'd0, 0, 0, 32'h0, 1, 1, 0);
        check("t5_fire", bus.compute_start_o, 1);
        step(0, 8'd0, 0, 0, 32'h0, 0, 0, 1);
        check("t5_waitd", {bus.compute_start_o, bus.done_o}, 2'b00);
        step(0, 8'd0, 0, 0, 32'h0, 0, 0, 0);
        check("t5_fin_done", {bus.done_o, bus.busy_o}, 2'b11);
        step(0, 8'd0, 0, 0, 32'h0, 0, 0, 0);
        check("t5_back_idle", {bus.done_o, bus.busy_o}, 2'b00);

        // Maximum tile count runs to completion without index wrap
        run_job(8'd255, 1'b0, 5000);

        // Asynchronous reset while waiting on compute for tile 1
        step(1, 8'd2, 0, 0, 32'h0, 0, 0, 0);
        n_cs = 0;
        pend = 1'b0;
        for (int c = 0; c < 100 && n_cs < 2; c++) begin
            step(0, 8'd0, 0, 1, 32'h0, 1, 1, pend);
            pend = 1'b0;
            if (bus.compute_start_o) begin
                n_cs++;
                if (n_cs == 1) pend = 1'b1;
            end
        end
        check("t6_reached_fire2", n_cs, 2);
        @(posedge clk); #1;
        drive(0, 8'd0, 0, 1, 32'h0, 1, 1, 0);
        #1;
        check("t6_pre_reset", {bus.busy_o, bus.tile_idx_o, bus.src_ready_o}, {1'b1, 8'd1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", outs(), 46'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 8'd0, 0, 1, 32'h0, 1, 1, 1);
        @(negedge clk);
        check("t6_idle_after", {bus.busy_o, bus.src_ready_o, bus.load_en_o, bus.done_o,
                                bus.compute_start_o, bus.tile_idx_o}, 13'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
